decode_stage: RTL and testbench

Registered, handshaked MIPS decode stage that replaces the combinational opcode/func decoder. It sits between the fetch stage and the execute stage. It decodes a widened R/I/J instruction subset into control and immediate fields, and it holds instructions back on register read-after-write and write-after-write hazards using a pending-write scoreboard. Writeback releases scoreboard entries, and a flush kills the decoded instruction that is waiting in the output register.

---
 rtl/decode_stage.sv | 200 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered, handshaked MIPS decode stage with a pending-write scoreboard.
// Incoming instructions are held on RAW/WAW hazards and on a full scoreboard.
module decode_stage #(
    parameter int DATA_W       = 32,
    parameter int HAZARD_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic [4:0]        wb_reg,
    output logic [DATA_W-1:0] out_pc,
    output logic              write_reg,
    output logic [4:0]        dst_reg,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [DATA_W-1:0] imm_ext,
    output logic [11:0]       alu_ctrl,
    output logic              mem_read,
    output logic              mem_write,
    output logic              branch,
    output logic              jump,
    output logic              illegal
);

    localparam int CNT_W = $clog2(HAZARD_DEPTH + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011,
                           OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDIU = 6'b001001,
                           OP_SLTI  = 6'b001010, OP_ANDI = 6'b001100, OP_ORI  = 6'b001101,
                           OP_XORI  = 6'b001110, OP_LUI  = 6'b001111, OP_LW   = 6'b100011,
                           OP_SW    = 6'b101011;
    localparam logic [5:0] F_SLL  = 6'b000000, F_SRL = 6'b000010, F_JR  = 6'b001000,
                           F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_AND = 6'b100100,
                           F_OR   = 6'b100101, F_XOR = 6'b100110, F_SLT = 6'b101010,
                           F_SLTU = 6'b101011;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic              write_reg;
        logic [4:0]        dst_reg;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [DATA_W-1:0] imm_ext;
        logic [11:0]       alu_ctrl;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              jump;
        logic              illegal;
    } bundle_t;

    logic [5:0]       opcode, func;
    bundle_t          dec;
    logic             use_rs, use_rt;
    bundle_t          out_q;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_wr, hazard, accept, issue, do_set, do_clr;
    logic [CNT_W:0]   occupancy;

    assign opcode = instr[31:26];
    assign func   = instr[5:0];

    // NOTE: every field gets a default before the case so no path leaves a value held (no latch).
    always_comb begin
        dec     = '0;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        dec.pc  = pc;
        dec.rs  = instr[25:21];
        dec.rt  = instr[20:16];
        dec.alu_ctrl = {opcode, 6'b0};
        case (opcode)
            OP_RTYPE: begin
                dec.alu_ctrl = {6'b0, func};
                case (func)
                    F_SLL, F_SRL: begin
                        dec.write_reg = 1'b1; dec.dst_reg = instr[15:11]; use_rt = 1'b1;
                    end
                    F_JR: begin
                        dec.jump = 1'b1; use_rs = 1'b1;
                    end
                    F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_SLT, F_SLTU: begin
                        dec.write_reg = 1'b1; dec.dst_reg = instr[15:11];
                        use_rs = 1'b1; use_rt = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_BEQ, OP_BNE: begin
                dec.imm_ext = DATA_W'($signed(instr[15:0]));
                dec.branch  = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
            end
            OP_ADDIU, OP_SLTI: begin
                dec.imm_ext   = DATA_W'($signed(instr[15:0]));
                dec.write_reg = 1'b1; dec.dst_reg = instr[20:16]; use_rs = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec.imm_ext   = DATA_W'(instr[15:0]);
                dec.write_reg = 1'b1; dec.dst_reg = instr[20:16]; use_rs = 1'b1;
            end
            OP_LUI: begin
                dec.imm_ext   = DATA_W'({instr[15:0], 16'h0000});
                dec.write_reg = 1'b1; dec.dst_reg = instr[20:16];
            end
            OP_LW: begin
                dec.imm_ext   = DATA_W'($signed(instr[15:0]));
                dec.mem_read  = 1'b1;
                dec.write_reg = 1'b1; dec.dst_reg = instr[20:16]; use_rs = 1'b1;
            end
            OP_SW: begin
                dec.imm_ext   = DATA_W'($signed(instr[15:0]));
                dec.mem_write = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
            end
            OP_J: begin
                dec.imm_ext = DATA_W'(instr[25:0]); dec.jump = 1'b1;
            end
            OP_JAL: begin
                dec.imm_ext   = DATA_W'(instr[25:0]); dec.jump = 1'b1;
                dec.write_reg = 1'b1; dec.dst_reg = 5'd31;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.alu_ctrl = 12'hFFF;
            use_rs = 1'b0;
            use_rt = 1'b0;
        end
        if (dec.dst_reg == 5'd0) dec.write_reg = 1'b0;
        if (dec.rs == 5'd0)      use_rs = 1'b0;
        if (dec.rt == 5'd0)      use_rt = 1'b0;
    end

    // The writer sitting in the output register is not yet in the scoreboard, so it is checked separately.
    always_comb begin
        out_wr    = out_valid_q && out_q.write_reg;
        occupancy = {1'b0, cnt_q} + (CNT_W + 1)'(out_wr);
        hazard    = 1'b0;
        if (use_rs && (pending_q[dec.rs] || (out_wr && out_q.dst_reg == dec.rs))) hazard = 1'b1;
        if (use_rt && (pending_q[dec.rt] || (out_wr && out_q.dst_reg == dec.rt))) hazard = 1'b1;
        if (dec.write_reg && (pending_q[dec.dst_reg] || (out_wr && out_q.dst_reg == dec.dst_reg)
                              || occupancy >= (CNT_W + 1)'(HAZARD_DEPTH))) hazard = 1'b1;
    end

    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;
    assign issue    = out_valid_q && out_ready && !flush;
    assign do_set   = issue && out_q.write_reg;
    assign do_clr   = wb_valid && pending_q[wb_reg];

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)       out_valid_d = 1'b0;
        else if (accept) out_valid_d = 1'b1;
        else if (issue)  out_valid_d = 1'b0;

        pending_d = pending_q;
        if (do_clr) pending_d[wb_reg] = 1'b0;
        if (do_set) pending_d[out_q.dst_reg] = 1'b1;
        cnt_d = cnt_q + CNT_W'(do_set) - CNT_W'(do_clr);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            pending_q   <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) out_q <= dec;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_q.pc;
    assign write_reg = out_q.write_reg;
    assign dst_reg   = out_q.dst_reg;
    assign rs        = out_q.rs;
    assign rt        = out_q.rt;
    assign imm_ext   = out_q.imm_ext;
    assign alu_ctrl  = out_q.alu_ctrl;
    assign mem_read  = out_q.mem_read;
    assign mem_write = out_q.mem_write;
    assign branch    = out_q.branch;
    assign jump      = out_q.jump;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: decode fields, RAW/WAW stalls, depth limit, flush, reset.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] instr, pc;
    logic        out_valid, out_ready, flush;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] out_pc, imm_ext;
    logic        write_reg;
    logic [4:0]  dst_reg, rs, rt;
    logic [11:0] alu_ctrl;
    logic        mem_read, mem_write, branch, jump, illegal;

    int checks = 0;
    int errors = 0;

    decode_stage #(.DATA_W(32), .HAZARD_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .wb_valid(wb_valid), .wb_reg(wb_reg),
        .out_pc(out_pc), .write_reg(write_reg), .dst_reg(dst_reg), .rs(rs), .rt(rt),
        .imm_ext(imm_ext), .alu_ctrl(alu_ctrl),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction, waits (bounded) for in_ready, lets it be accepted, then drops in_valid.
    task automatic load(input logic [31:0] ins, input logic [31:0] p);
        int n = 0;
        in_valid = 1'b1; instr = ins; pc = p;
        #1;
        while (in_ready !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL load_ready %h: got %b want 1", ins, in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic retire(input logic [4:0] r);
        wb_valid = 1'b1; wb_reg = r;
        tick();
        wb_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; instr = 32'h0; pc = 32'h0; out_ready = 1'b1;
        flush = 1'b0; wb_valid = 1'b0; wb_reg = 5'd0;
        #12 rst_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (write_reg !== 1'b0) begin errors++; $display("FAIL rst_write_reg: got %b want 0", write_reg); end
        checks++; if (alu_ctrl !== 12'h000) begin errors++; $display("FAIL rst_alu_ctrl: got %h want 000", alu_ctrl); end
        checks++; if (imm_ext !== 32'h0 || out_pc !== 32'h0) begin
            errors++; $display("FAIL rst_imm_pc: got %h/%h want 0/0", imm_ext, out_pc); end
        checks++; if ({mem_read, mem_write, branch, jump, illegal} !== 5'b0) begin
            errors++; $display("FAIL rst_flags: got %b want 00000", {mem_read, mem_write, branch, jump, illegal}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_addiu();
        out_ready = 1'b0;
        load(32'h2509FFFC, 32'h0000_0100);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addiu_valid: got %b want 1", out_valid); end
        checks++; if (write_reg !== 1'b1 || dst_reg !== 5'd9) begin
            errors++; $display("FAIL addiu_dst: got %b/%0d want 1/9", write_reg, dst_reg); end
        checks++; if (alu_ctrl !== 12'h240) begin errors++; $display("FAIL addiu_alu: got %h want 240", alu_ctrl); end
        checks++; if (imm_ext !== 32'hFFFFFFFC) begin errors++; $display("FAIL addiu_imm: got %h want fffffffc", imm_ext); end
        checks++; if (out_pc !== 32'h100 || rs !== 5'd8 || rt !== 5'd9) begin
            errors++; $display("FAIL addiu_fields: got pc %h rs %0d rt %0d want 100 8 9", out_pc, rs, rt); end
        tick();
        checks++; if (out_valid !== 1'b1 || dst_reg !== 5'd9) begin
            errors++; $display("FAIL addiu_hold: got %b/%0d want 1/9", out_valid, dst_reg); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addiu_issue: got %b want 0", out_valid); end
        instr = 32'h01296821;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL addiu_pending: got %b want 0", in_ready); end
        retire(5'd9);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addiu_retired: got %b want 1", in_ready); end
    endtask

    task automatic test_raw_hazard();
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h00221821; pc = 32'h200;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_addu_ready: got %b want 1", in_ready); end
        tick();
        instr = 32'h00612023; pc = 32'h204;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_outreg: got %b want 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL raw_pending: got ready %b valid %b want 0 0", in_ready, out_valid); end
        tick();
        wb_valid = 1'b1; wb_reg = 5'd3;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_no_bypass: got %b want 0", in_ready); end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_released: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || alu_ctrl !== 12'h023 || dst_reg !== 5'd4 || out_pc !== 32'h204) begin
            errors++; $display("FAIL raw_subu: got v %b alu %h dst %0d pc %h want 1 023 4 204",
                               out_valid, alu_ctrl, dst_reg, out_pc); end
        tick();
        retire(5'd4);
    endtask

    task automatic test_depth();
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h240A0001;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL depth_first: got %b want 1", in_ready); end
        tick();
        instr = 32'h240B0001;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL depth_second: got %b want 1", in_ready); end
        tick();
        instr = 32'h240C0001;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL depth_third_held: got %b want 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL depth_full: got ready %b valid %b want 0 0", in_ready, out_valid); end
        wb_valid = 1'b1; wb_reg = 5'd10;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL depth_wb_cycle: got %b want 0", in_ready); end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL depth_release: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || dst_reg !== 5'd12) begin
            errors++; $display("FAIL depth_third_out: got %b/%0d want 1/12", out_valid, dst_reg); end
        tick();
        retire(5'd11);
        retire(5'd12);
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic        wr;
        logic [11:0] alu;
        logic [4:0]  flags; // {mem_read, mem_write, branch, jump, illegal}
    } vec_t;

    task automatic test_decode();
        vec_t v [7];
        v[0] = '{32'h34058000, 32'h00008000, 5'd5,  1'b1, 12'h340, 5'b00000}; // ori $5,$0,0x8000
        v[1] = '{32'h3C061234, 32'h12340000, 5'd6,  1'b1, 12'h3C0, 5'b00000}; // lui $6,0x1234
        v[2] = '{32'h0C100000, 32'h00100000, 5'd31, 1'b1, 12'h0C0, 5'b00010}; // jal
        v[3] = '{32'h8C47FFF8, 32'hFFFFFFF8, 5'd7,  1'b1, 12'h8C0, 5'b10000}; // lw $7,-8($2)
        v[4] = '{32'h10220004, 32'h00000004, 5'd0,  1'b0, 12'h100, 5'b00100}; // beq $1,$2,4
        v[5] = '{32'hAC220008, 32'h00000008, 5'd0,  1'b0, 12'hAC0, 5'b01000}; // sw $2,8($1)
        v[6] = '{32'h03E00008, 32'h00000000, 5'd0,  1'b0, 12'h008, 5'b00010}; // jr $31
        for (int i = 0; i < 7; i++) begin
            out_ready = 1'b0;
            load(v[i].ins, 32'h300 + 32'(i * 4));
            checks++;
            if (imm_ext !== v[i].imm || write_reg !== v[i].wr || alu_ctrl !== v[i].alu ||
                {mem_read, mem_write, branch, jump, illegal} !== v[i].flags ||
                (v[i].wr && dst_reg !== v[i].dst)) begin
                errors++;
                $display("FAIL decode_%0d: got imm %h wr %b dst %0d alu %h fl %b want %h %b %0d %h %b", i,
                         imm_ext, write_reg, dst_reg, alu_ctrl, {mem_read, mem_write, branch, jump, illegal},
                         v[i].imm, v[i].wr, v[i].dst, v[i].alu, v[i].flags);
            end
            out_ready = 1'b1;
            tick();
            if (v[i].wr) retire(v[i].dst);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b0;
        load(32'hFC0A0000, 32'h400);
        checks++; if (illegal !== 1'b1 || alu_ctrl !== 12'hFFF || write_reg !== 1'b0) begin
            errors++; $display("FAIL illegal_fields: got ill %b alu %h wr %b want 1 fff 0", illegal, alu_ctrl, write_reg); end
        checks++; if ({mem_read, mem_write, branch, jump} !== 4'b0 || imm_ext !== 32'h0) begin
            errors++; $display("FAIL illegal_flags: got %b imm %h want 0000 0", {mem_read, mem_write, branch, jump}, imm_ext); end
        out_ready = 1'b1;
        tick();
        instr = 32'h014A6821;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL illegal_no_entry: got %b want 1", in_ready); end
        out_ready = 1'b0;
        load(32'h00220021, 32'h404);
        checks++; if (write_reg !== 1'b0 || alu_ctrl !== 12'h021 || illegal !== 1'b0) begin
            errors++; $display("FAIL addu_r0: got wr %b alu %h ill %b want 0 021 0", write_reg, alu_ctrl, illegal); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        load(32'h240A0001, 32'h500);
        tick();
        out_ready = 1'b0;
        load(32'h2509FFFC, 32'h504);
        tick();
        checks++; if (out_valid !== 1'b1 || dst_reg !== 5'd9) begin
            errors++; $display("FAIL flush_held: got %b/%0d want 1/9", out_valid, dst_reg); end
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; instr = 32'h240E0001;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        instr = 32'h01296821;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_no_issue: got %b want 1", in_ready); end
        instr = 32'h014A6821;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_keeps_pending: got %b want 0", in_ready); end
        retire(5'd10);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_retire: got %b want 1", in_ready); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        load(32'h240A0001, 32'h600);
        tick();
        out_ready = 1'b0;
        load(32'h240B0001, 32'h604);
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || dst_reg !== 5'd0) begin
            errors++; $display("FAIL midrst_out: got %b/%0d want 0/0", out_valid, dst_reg); end
        #1 rst_n = 1'b1;
        out_ready = 1'b1; instr = 32'h014A6821;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_scoreboard: got %b want 1", in_ready); end
        tick();
    endtask

    initial begin
        test_reset();
        test_addiu();
        test_raw_hazard();
        test_depth();
        test_decode();
        test_illegal();
        test_flush();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
